axi_lite_regfile: RTL and testbench
===================================

Name: axi_lite_regfile

Overview:
AXI-Lite responder that terminates an axi_lite_channel and implements a bank of NUM_REGS word-wide registers. Sits at the slave end of an interconnect path, typically behind axi_lite_buf, and provides control/status registers to a peripheral. Read-write registers drive outputs to the peripheral; read-only registers return live hardware status. Write and read paths are independent and allow one transaction outstanding each.

Parameters:
NUM_REGS, 16, number of DATA_WIDTH-bit registers (>=1)
ADDR_WIDTH, 48, AXI-Lite address width; must equal host.ADDR_WIDTH, else $fatal
DATA_WIDTH, 64, register/data width (32 or 64); must equal host.DATA_WIDTH, else $fatal
RO_MASK, 0, NUM_REGS-bit mask; bit i set = register i read-only (returns status_i slice)

Ports:
clk  input  1  clock; the single clock domain for the block and the host interface
rstn  input  1  asynchronous active-low reset
host  axi_lite_channel.slave  -  AXI-Lite port from the upstream master
regs_o  output  NUM_REGS*DATA_WIDTH  current RW register values, register i at [i*DATA_WIDTH +: DATA_WIDTH]
wr_pulse_o  output  NUM_REGS  one-cycle pulse, bit i, when register i commits a successful write
status_i  input  NUM_REGS*DATA_WIDTH  read value for RO registers (same slicing); ignored for RW

Behaviour:
- Reset (async, rstn low): all RW registers 0, regs_o 0, wr_pulse_o 0, b_valid/r_valid 0, AW/W holding regs empty, aw_ready/w_ready/ar_ready 1 after reset release. b_resp, r_resp, r_data reset to 0.
- Word index = addr[ADDR_WIDTH-1:$clog2(DATA_WIDTH/8)]; low bits ignored. prot is accepted and ignored.
- Response codes: OKAY 2'b00; SLVERR 2'b10 for a write to an RO register; DECERR 2'b11 for index >= NUM_REGS (read or write).
- AW and W are captured independently in one-entry holding registers: aw_ready = !aw_held, w_ready = !w_held. Either order, or the same cycle, is legal.
- Commit: on the edge after both aw_held and w_held are set and b_valid is 0: apply the write, clear both holds, set b_valid with its resp. Therefore AW+W handshakes at edge N -> regs_o updated and b_valid high after edge N+1. If b_valid is still pending, the commit stalls; holds stay full, and AW/W backpressure.
- Write data is applied byte-wise per w_strb; strb=0 is legal, returns OKAY, leaves the register unchanged, and still pulses wr_pulse_o.
- wr_pulse_o[i] is high for exactly the cycle following the commit edge (aligned with regs_o update), only for OKAY writes.
- b_valid stays high with b_resp stable until b_ready; it clears on the handshake edge. A new commit can occur on the same edge that b handshakes (stall-free back-to-back).
- Read: ar_ready = !r_valid || r_ready. AR handshake at edge N -> r_valid, r_data and r_resp registered after edge N. RO register -> status_i slice sampled at edge N; RW -> register value; DECERR -> r_data 0. These are held stable until r_ready.
- Read/write same register, same edge: read returns the pre-write value.
- Reset mid-transaction: all pending holds and responses are dropped immediately; no partial write is applied.

Decomposition:
- resp_t and prot_t come from the shared AXI package; add RESP_OKAY/SLVERR/DECERR localparams there if not present.
- No sub-module is needed; the AW/W holds are inline registers. Use an external axi_lite_buf for timing isolation rather than internal FIFOs.

Test Plan:
- AW(addr 0x08) and W(data 0xDEAD_BEEF_0123_4567, strb 0xFF) in the same cycle -> regs_o reg1 = that value and wr_pulse_o = 0x0002 one cycle after, b_resp OKAY the same cycle.
- W first, AW 3 cycles later, strb 0x0F on reg0 = 0xFFFF_FFFF_FFFF_FFFF with data 0 -> reg0 = 0xFFFF_FFFF_0000_0000, OKAY; w_ready low while W is held.
- Hold b_ready low for 5 cycles, issue a second AW+W -> aw_ready/w_ready drop after capture; the second write commits on the b handshake edge; the two b responses are in order.
- Write to reg 3 with RO_MASK bit 3 set -> SLVERR, regs_o unchanged, no pulse; a read of reg 3 with status_i = 0x55 -> r_data 0x55 OKAY.
- Read and write to index 16 with NUM_REGS = 16 -> DECERR on both, r_data 0.
- Read reg2 while a write to reg2 commits on the same edge -> old value returned; a subsequent read returns the new value. Assert rstn low mid-hold -> no write applied, all valid signals 0.

Source files
------------

// File: rtl/axi_lite_regfile_pkg.sv
// Shared AXI-Lite types, response codes and the byte-strobe merge helper
// used by the register file.
package axi_lite_regfile_pkg;

    typedef logic [1:0] resp_t;
    typedef logic [2:0] prot_t;

    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;

    localparam int MAX_DATA_WIDTH = 64;
    localparam int MAX_STRB_WIDTH = MAX_DATA_WIDTH / 8;

    // Replace only the bytes whose strobe bit is set; narrower buses are zero-extended by the caller.
    function automatic logic [MAX_DATA_WIDTH-1:0] strb_merge(
        input logic [MAX_DATA_WIDTH-1:0] old_v,
        input logic [MAX_DATA_WIDTH-1:0] new_v,
        input logic [MAX_STRB_WIDTH-1:0] strb
    );
        logic [MAX_DATA_WIDTH-1:0] mask_v;
        mask_v = '0;
        for (int b = 0; b < MAX_STRB_WIDTH; b++) begin
            mask_v[b*8 +: 8] = {8{strb[b]}};
        end
        return (old_v & ~mask_v) | (new_v & mask_v);
    endfunction

endpackage

// File: rtl/axi_lite_channel.sv
// AXI-Lite channel bundle shared between an upstream master and a responder.
interface axi_lite_channel #(
    parameter int ADDR_WIDTH = 48,
    parameter int DATA_WIDTH = 64
);
    logic                                aw_valid;
    logic                                aw_ready;
    logic [ADDR_WIDTH-1:0]               aw_addr;
    axi_lite_regfile_pkg::prot_t         aw_prot;

    logic                                w_valid;
    logic                                w_ready;
    logic [DATA_WIDTH-1:0]               w_data;
    logic [DATA_WIDTH/8-1:0]             w_strb;

    logic                                b_valid;
    logic                                b_ready;
    axi_lite_regfile_pkg::resp_t         b_resp;

    logic                                ar_valid;
    logic                                ar_ready;
    logic [ADDR_WIDTH-1:0]               ar_addr;
    axi_lite_regfile_pkg::prot_t         ar_prot;

    logic                                r_valid;
    logic                                r_ready;
    logic [DATA_WIDTH-1:0]               r_data;
    axi_lite_regfile_pkg::resp_t         r_resp;

    modport master (
        output aw_valid, aw_addr, aw_prot, input aw_ready,
        output w_valid, w_data, w_strb, input w_ready,
        input b_valid, b_resp, output b_ready,
        output ar_valid, ar_addr, ar_prot, input ar_ready,
        input r_valid, r_data, r_resp, output r_ready
    );

    modport slave (
        input aw_valid, aw_addr, aw_prot, output aw_ready,
        input w_valid, w_data, w_strb, output w_ready,
        output b_valid, b_resp, input b_ready,
        input ar_valid, ar_addr, ar_prot, output ar_ready,
        output r_valid, r_data, r_resp, input r_ready
    );

endinterface

// File: rtl/axi_lite_regfile.sv
// AXI-Lite register bank: NUM_REGS word registers, RW ones driven to the
// peripheral, RO ones returning live status. One write and one read in flight.
module axi_lite_regfile
    import axi_lite_regfile_pkg::*;
#(
    parameter int                  NUM_REGS   = 16,
    parameter int                  ADDR_WIDTH = 48,
    parameter int                  DATA_WIDTH = 64,
    parameter logic [NUM_REGS-1:0] RO_MASK    = '0
) (
    input  logic                           clk,
    input  logic                           rstn,
    axi_lite_channel.slave                 host,
    output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
    output logic [NUM_REGS-1:0]            wr_pulse_o,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] status_i
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int OFFS       = $clog2(STRB_WIDTH);
    localparam int IDX_W      = ADDR_WIDTH - OFFS;

    if ($bits(host.aw_addr) != ADDR_WIDTH) begin : g_addr_width_mismatch
        $fatal(1, "axi_lite_regfile: ADDR_WIDTH does not match host channel");
    end
    if ($bits(host.w_data) != DATA_WIDTH) begin : g_data_width_mismatch
        $fatal(1, "axi_lite_regfile: DATA_WIDTH does not match host channel");
    end
    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_data_width_illegal
        $fatal(1, "axi_lite_regfile: DATA_WIDTH must be 32 or 64");
    end
    if (NUM_REGS < 1) begin : g_num_regs_illegal
        $fatal(1, "axi_lite_regfile: NUM_REGS must be at least 1");
    end

    logic                                 aw_held_q, aw_held_d;
    logic [IDX_W-1:0]                     aw_word_q, aw_word_d;
    logic                                 w_held_q, w_held_d;
    logic [DATA_WIDTH-1:0]                w_data_q, w_data_d;
    logic [STRB_WIDTH-1:0]                w_strb_q, w_strb_d;
    logic                                 b_valid_q, b_valid_d;
    resp_t                                b_resp_q, b_resp_d;
    logic                                 r_valid_q, r_valid_d;
    logic [DATA_WIDTH-1:0]                r_data_q, r_data_d;
    resp_t                                r_resp_q, r_resp_d;
    logic [NUM_REGS-1:0][DATA_WIDTH-1:0]  regs_q, regs_d;
    logic [NUM_REGS-1:0]                  wr_pulse_q, wr_pulse_d;

    logic                                 aw_fire_s;
    logic                                 w_fire_s;
    logic                                 ar_fire_s;
    logic                                 commit_s;
    logic [IDX_W-1:0]                     ar_word_s;
    logic [NUM_REGS-1:0]                  wr_sel_s;
    logic [NUM_REGS-1:0]                  rd_sel_s;
    logic [DATA_WIDTH-1:0]                wr_old_s;
    logic [DATA_WIDTH-1:0]                rd_val_s;
    logic [MAX_DATA_WIDTH-1:0]            wr_merged_s;
    resp_t                                wr_resp_s;
    logic                                 unused_s;

    assign host.aw_ready = ~aw_held_q;
    assign host.w_ready  = ~w_held_q;
    assign host.ar_ready = ~r_valid_q | host.r_ready;
    assign host.b_valid  = b_valid_q;
    assign host.b_resp   = b_resp_q;
    assign host.r_valid  = r_valid_q;
    assign host.r_data   = r_data_q;
    assign host.r_resp   = r_resp_q;

    assign regs_o     = regs_q;
    assign wr_pulse_o = wr_pulse_q;

    assign aw_fire_s = host.aw_valid & ~aw_held_q;
    assign w_fire_s  = host.w_valid & ~w_held_q;
    assign ar_fire_s = host.ar_valid & (~r_valid_q | host.r_ready);
    // A pending B response that is being accepted this edge does not block the next commit.
    assign commit_s  = aw_held_q & w_held_q & (~b_valid_q | host.b_ready);
    assign ar_word_s = host.ar_addr[ADDR_WIDTH-1:OFFS];

    assign wr_merged_s = strb_merge(MAX_DATA_WIDTH'(wr_old_s), MAX_DATA_WIDTH'(w_data_q),
                                    MAX_STRB_WIDTH'(w_strb_q));

    assign unused_s = ^{host.aw_addr[OFFS-1:0], host.ar_addr[OFFS-1:0],
                        host.aw_prot, host.ar_prot, status_i, wr_merged_s};

    // Decode held write index and incoming read index into one-hot selects
    always_comb begin
        wr_sel_s = '0;
        rd_sel_s = '0;
        wr_old_s = '0;
        rd_val_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (aw_word_q == IDX_W'(i)) begin
                wr_sel_s[i] = 1'b1;
                wr_old_s    = regs_q[i];
            end else begin
                wr_sel_s[i] = 1'b0;
            end
            if (ar_word_s == IDX_W'(i)) begin
                rd_sel_s[i] = 1'b1;
                rd_val_s    = RO_MASK[i] ? status_i[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
            end else begin
                rd_sel_s[i] = 1'b0;
            end
        end
    end

    // Classify the held write: out of range, read-only target, or accepted
    always_comb begin
        if (~|wr_sel_s) begin
            wr_resp_s = RESP_DECERR;
        end else if (|(wr_sel_s & RO_MASK)) begin
            wr_resp_s = RESP_SLVERR;
        end else begin
            wr_resp_s = RESP_OKAY;
        end
    end

    // AW/W holding registers, write commit and B response
    always_comb begin
        aw_held_d  = aw_held_q;
        aw_word_d  = aw_word_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        b_valid_d  = b_valid_q;
        b_resp_d   = b_resp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;

        if (aw_fire_s) begin
            aw_held_d = 1'b1;
            aw_word_d = host.aw_addr[ADDR_WIDTH-1:OFFS];
        end else if (commit_s) begin
            aw_held_d = 1'b0;
        end else begin
            aw_held_d = aw_held_q;
        end

        if (w_fire_s) begin
            w_held_d = 1'b1;
            w_data_d = host.w_data;
            w_strb_d = host.w_strb;
        end else if (commit_s) begin
            w_held_d = 1'b0;
        end else begin
            w_held_d = w_held_q;
        end

        if (commit_s) begin
            b_valid_d = 1'b1;
            b_resp_d  = wr_resp_s;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_sel_s[i] && !RO_MASK[i]) begin
                    regs_d[i]     = wr_merged_s[DATA_WIDTH-1:0];
                    wr_pulse_d[i] = 1'b1;
                end else begin
                    regs_d[i]     = regs_q[i];
                    wr_pulse_d[i] = 1'b0;
                end
            end
        end else if (b_valid_q && host.b_ready) begin
            b_valid_d = 1'b0;
        end else begin
            b_valid_d = b_valid_q;
        end
    end

    // Read response capture; data and code are frozen until the R handshake
    always_comb begin
        r_valid_d = r_valid_q;
        r_data_d  = r_data_q;
        r_resp_d  = r_resp_q;
        if (ar_fire_s) begin
            r_valid_d = 1'b1;
            r_data_d  = rd_val_s;
            r_resp_d  = (|rd_sel_s) ? RESP_OKAY : RESP_DECERR;
        end else if (r_valid_q && host.r_ready) begin
            r_valid_d = 1'b0;
        end else begin
            r_valid_d = r_valid_q;
        end
    end

    // State registers; reset drops any half-built write and pending responses
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_held_q  <= 1'b0;
            aw_word_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            regs_q     <= '0;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            aw_word_q  <= aw_word_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            b_valid_q  <= b_valid_d;
            b_resp_q   <= b_resp_d;
            r_valid_q  <= r_valid_d;
            r_data_q   <= r_data_d;
            r_resp_q   <= r_resp_d;
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
        end
    end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// Self-checking bench for axi_lite_regfile: directed scenarios plus random
// traffic scored against an array model of the register bank.
module tb_axi_lite_regfile;
    import axi_lite_regfile_pkg::*;

    localparam int NR = 16;
    localparam int AW = 48;
    localparam int DW = 64;
    localparam logic [NR-1:0] RO = 16'h0028;

    logic              clk;
    logic              rstn;
    logic [NR*DW-1:0]  regs_o;
    logic [NR-1:0]     wr_pulse_o;
    logic [NR*DW-1:0]  status_i;

    int checks;
    int failures;
    logic [DW-1:0] model [NR];

    axi_lite_channel #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) host ();

    axi_lite_regfile #(
        .NUM_REGS(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RO_MASK(RO)
    ) dut (
        .clk(clk), .rstn(rstn), .host(host),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o), .status_i(status_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [1:0] exp_wresp(input int idx);
        if (idx >= NR) return RESP_DECERR;
        else if (RO[idx]) return RESP_SLVERR;
        else return RESP_OKAY;
    endfunction

    task automatic model_apply(input int idx, input logic [DW-1:0] data, input logic [7:0] strb);
        for (int b = 0; b < DW/8; b++) begin
            if (strb[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
        end
    endtask

    task automatic check_all_regs(input string tag);
        for (int i = 0; i < NR; i++) begin
            check_eq($sformatf("%s_reg%0d", tag, i), 64'(regs_o[i*DW +: DW]), 64'(model[i]));
        end
    endtask

    task automatic send_aw_w(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [7:0] strb, input int aw_dly, input int w_dly);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire;
        cyc = 0; aw_done = 1'b0; w_done = 1'b0;
        host.aw_addr = addr; host.aw_prot = 3'($urandom);
        host.w_data = data; host.w_strb = strb;
        while (!(aw_done && w_done) && cyc < 64) begin
            host.aw_valid = !aw_done && (cyc >= aw_dly);
            host.w_valid  = !w_done && (cyc >= w_dly);
            aw_fire = host.aw_valid && host.aw_ready;
            w_fire  = host.w_valid && host.w_ready;
            @(posedge clk); #1;
            if (aw_fire) aw_done = 1'b1;
            if (w_fire) w_done = 1'b1;
            if (w_done && !aw_done) check_eq("w_ready_while_held", 64'(host.w_ready), 64'(0));
            if (aw_done && !w_done) check_eq("aw_ready_while_held", 64'(host.aw_ready), 64'(0));
            cyc++;
        end
        host.aw_valid = 1'b0;
        host.w_valid  = 1'b0;
        check_eq("aw_w_accepted", 64'({aw_done, w_done}), 64'(2'b11));
    endtask

    task automatic expect_b(input logic [1:0] resp, input int idx, input bit chk_lat);
        int lat;
        logic [NR-1:0] ep;
        ep = '0;
        if (resp == RESP_OKAY) ep[idx] = 1'b1;
        lat = 0;
        while (!host.b_valid && lat < 32) begin
            @(posedge clk); #1;
            lat++;
        end
        check_eq("b_valid_seen", 64'(host.b_valid), 64'(1));
        if (chk_lat) check_eq("b_latency", 64'(lat), 64'(1));
        check_eq("b_resp", 64'(host.b_resp), 64'(resp));
        check_eq("wr_pulse", 64'(wr_pulse_o), 64'(ep));
        check_all_regs("wr");
        if (host.b_ready) begin
            @(posedge clk); #1;
            check_eq("b_cleared", 64'(host.b_valid), 64'(0));
            check_eq("wr_pulse_cleared", 64'(wr_pulse_o), 64'(0));
        end
    endtask

    task automatic model_write(input int idx, input logic [DW-1:0] data, input logic [7:0] strb,
                               input int aw_dly, input int w_dly);
        logic [1:0] r;
        r = exp_wresp(idx);
        if (r == RESP_OKAY) model_apply(idx, data, strb);
        send_aw_w(AW'(idx*8 + int'($urandom_range(0, 7))), data, strb, aw_dly, w_dly);
        expect_b(r, idx, 1'b1);
    endtask

    task automatic model_read(input int idx);
        logic [DW-1:0] ed;
        logic [1:0] er;
        int cyc;
        bit fired, fire;
        if (idx >= NR) begin
            ed = '0; er = RESP_DECERR;
        end else if (RO[idx]) begin
            ed = status_i[idx*DW +: DW]; er = RESP_OKAY;
        end else begin
            ed = model[idx]; er = RESP_OKAY;
        end
        host.ar_addr = AW'(idx*8 + int'($urandom_range(0, 7)));
        host.ar_prot = 3'($urandom);
        host.ar_valid = 1'b1;
        cyc = 0; fired = 1'b0;
        while (!fired && cyc < 32) begin
            fire = host.ar_ready;
            @(posedge clk); #1;
            if (fire) fired = 1'b1;
            cyc++;
        end
        host.ar_valid = 1'b0;
        check_eq("r_valid", 64'(host.r_valid), 64'(1));
        check_eq($sformatf("r_data_idx%0d", idx), 64'(host.r_data), 64'(ed));
        check_eq("r_resp", 64'(host.r_resp), 64'(er));
        @(posedge clk); #1;
        check_eq("r_cleared", 64'(host.r_valid), 64'(0));
    endtask

    task automatic randomize_status();
        for (int k = 0; k < NR*DW/32; k++) status_i[k*32 +: 32] = $urandom;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] d_old, d_new;
        int op, idx;
        checks = 0; failures = 0;
        rstn = 1'b0;
        host.aw_valid = 1'b0; host.aw_addr = '0; host.aw_prot = '0;
        host.w_valid = 1'b0; host.w_data = '0; host.w_strb = '0;
        host.b_ready = 1'b1;
        host.ar_valid = 1'b0; host.ar_addr = '0; host.ar_prot = '0;
        host.r_ready = 1'b1;
        status_i = '0;
        for (int i = 0; i < NR; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;

        check_eq("rst_regs_zero", 64'(|regs_o), 64'(0));
        check_eq("rst_pulse", 64'(wr_pulse_o), 64'(0));
        check_eq("rst_b_valid", 64'(host.b_valid), 64'(0));
        check_eq("rst_r_valid", 64'(host.r_valid), 64'(0));
        check_eq("rst_readys", 64'({host.aw_ready, host.w_ready, host.ar_ready}), 64'(3'b111));

        // Same-cycle AW+W to reg1
        model_write(1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 0, 0);
        check_eq("t1_reg1", 64'(regs_o[1*DW +: DW]), 64'hDEAD_BEEF_0123_4567);

        // W first, AW three cycles later, low-half strobe
        model_write(0, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, 0);
        model_write(0, 64'h0, 8'h0F, 3, 0);
        check_eq("t2_reg0", 64'(regs_o[DW-1:0]), 64'hFFFF_FFFF_0000_0000);

        // Zero strobe still pulses and leaves the register alone
        model_write(4, {$urandom, $urandom}, 8'h00, 1, 0);

        // B backpressure: SLVERR pending, then an OKAY write queued behind it
        host.b_ready = 1'b0;
        send_aw_w(AW'(5*8), {$urandom, $urandom}, 8'hFF, 0, 0);
        expect_b(RESP_SLVERR, 5, 1'b1);
        repeat (5) begin
            @(posedge clk); #1;
            check_eq("bp_b_held", 64'({host.b_valid, host.b_resp}), 64'({1'b1, RESP_SLVERR}));
        end
        d_new = {$urandom, $urandom};
        send_aw_w(AW'(7*8), d_new, 8'hFF, 0, 0);
        check_eq("bp_aw_ready_low", 64'(host.aw_ready), 64'(0));
        check_eq("bp_w_ready_low", 64'(host.w_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check_eq("bp_reg7_stalled", 64'(regs_o[7*DW +: DW]), 64'(model[7]));
        model[7] = d_new;
        host.b_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("bp_second_b", 64'({host.b_valid, host.b_resp}), 64'({1'b1, RESP_OKAY}));
        check_eq("bp_second_pulse", 64'(wr_pulse_o), 64'(16'h0080));
        check_eq("bp_reg7", 64'(regs_o[7*DW +: DW]), 64'(d_new));
        check_eq("bp_aw_ready_back", 64'(host.aw_ready), 64'(1));
        @(posedge clk); #1;
        check_eq("bp_b_done", 64'(host.b_valid), 64'(0));

        // Read-only register: write rejected, read returns status
        model_write(3, {$urandom, $urandom}, 8'hFF, 0, 2);
        status_i[3*DW +: DW] = 64'h55;
        model_read(3);
        check_eq("ro_reg3_regs_o", 64'(regs_o[3*DW +: DW]), 64'(0));

        // Out-of-range index on both paths
        model_write(16, {$urandom, $urandom}, 8'hFF, 0, 0);
        model_read(16);

        // Read and commit to reg2 on the same edge
        model_write(2, {$urandom, $urandom}, 8'hFF, 0, 0);
        d_old = model[2];
        d_new = ~d_old;
        host.aw_addr = AW'(2*8); host.w_data = d_new; host.w_strb = 8'hFF;
        host.aw_valid = 1'b1; host.w_valid = 1'b1;
        @(posedge clk); #1;
        host.aw_valid = 1'b0; host.w_valid = 1'b0;
        check_eq("se_holds_full", 64'({host.aw_ready, host.w_ready}), 64'(2'b00));
        host.ar_addr = AW'(2*8 + 3); host.ar_valid = 1'b1;
        @(posedge clk); #1;
        host.ar_valid = 1'b0;
        model[2] = d_new;
        check_eq("se_r_valid", 64'(host.r_valid), 64'(1));
        check_eq("se_r_old", 64'(host.r_data), 64'(d_old));
        check_eq("se_b_valid", 64'(host.b_valid), 64'(1));
        check_eq("se_reg2_new", 64'(regs_o[2*DW +: DW]), 64'(d_new));
        @(posedge clk); #1;
        model_read(2);

        // Random traffic against the model
        for (int it = 0; it < 80; it++) begin
            op = int'($urandom_range(0, 2));
            idx = int'($urandom_range(0, NR + 1));
            if (op == 0) randomize_status();
            if (op < 2) begin
                model_write(idx, {$urandom, $urandom}, 8'($urandom),
                            int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            end else begin
                model_read(idx);
            end
        end

        // Reset while a W beat is held
        host.w_data = 64'h1234_5678_9ABC_DEF0; host.w_strb = 8'hFF; host.w_valid = 1'b1;
        @(posedge clk); #1;
        host.w_valid = 1'b0;
        check_eq("mid_w_held", 64'(host.w_ready), 64'(0));
        rstn = 1'b0;
        #1;
        for (int i = 0; i < NR; i++) model[i] = '0;
        check_eq("mid_rst_valids", 64'({host.b_valid, host.r_valid}), 64'(2'b00));
        check_eq("mid_rst_readys", 64'({host.aw_ready, host.w_ready}), 64'(2'b11));
        check_eq("mid_rst_regs", 64'(|regs_o), 64'(0));
        @(posedge clk); #1;
        rstn = 1'b1;
        host.aw_addr = AW'(1*8); host.aw_valid = 1'b1;
        @(posedge clk); #1;
        host.aw_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("mid_no_commit", 64'(host.b_valid), 64'(0));
        check_eq("mid_reg1_clear", 64'(regs_o[1*DW +: DW]), 64'(0));
        d_new = {$urandom, $urandom};
        model[1] = d_new;
        host.w_data = d_new; host.w_valid = 1'b1;
        @(posedge clk); #1;
        host.w_valid = 1'b0;
        expect_b(RESP_OKAY, 1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
